niosii_system_servo_pwm: RTL
============================

Name: niosII_system_servo_pwm

Overview:
- Avalon-MM slave peripheral on the Nios II data bus, alongside the system ID slave.
- Generates NUM_CH servo PWM outputs with a shared programmable frame period and per-channel pulse widths.
- Software-written values go to shadow registers and become active only at a frame boundary, so pulses are never glitched.
- A sticky frame-done flag with an optional interrupt lets firmware pace its updates.

Parameters:
NUM_CH, 4, number of PWM channels (1..4; pulse register addresses 4..7)
CNT_W, 20, width of the frame counter and period/pulse fields
DEFAULT_PERIOD, 1000000, reset period in clocks (20 ms at 50 MHz)
DEFAULT_PULSE, 75000, reset pulse width per channel in clocks (1.5 ms)

Ports:
clock  input  1  system clock; all logic on the rising edge
reset_n  input  1  asynchronous, active-low reset
address  input  3  word address of the register
chipselect  input  1  slave select
read  input  1  read strobe, qualified by chipselect
write  input  1  write strobe, qualified by chipselect
writedata  input  32  write data
readdata  output  32  registered read data, read latency 1
pwm_out  output  NUM_CH  registered servo pulse outputs
irq  output  1  level interrupt, equal to done & irq_en

Behaviour:
- Register map (word addresses):
  - 0 CTRL: bit0 enable, bit1 irq_en, RW.
  - 1 STATUS: bit0 done (sticky), write 1 to clear.
  - 2 PERIOD: RW, low CNT_W bits.
  - 3: reserved, reads 0, writes ignored.
  - 4..7 PULSE[0..3]: RW, low CNT_W bits.
  - Unused upper bits and channels at or above NUM_CH read 0.
- Reset values:
  - CTRL=0, done=0, PERIOD=DEFAULT_PERIOD, PULSE[i]=DEFAULT_PULSE.
  - Active shadows equal the same defaults.
  - cnt=0, state=IDLE, pwm_out=0, readdata=0, irq=0.
- Bus timing:
  - Writes take effect on the clock edge where chipselect & write.
  - Reads: readdata is loaded on the edge where chipselect & read, and holds its value otherwise.
  - Read and write in the same cycle: the write is applied and readdata returns the pre-write value.
- State machine, IDLE:
  - cnt held at 0, pwm_out=0.
  - When enable=1, go to RUN: load active_period and active_pulse[] from the programmed registers, cnt=0.
- State machine, RUN:
  - If cnt == active_period-1: cnt wraps to 0, shadows reload from the programmed registers, done is set.
  - Otherwise cnt increments.
  - enable=0 at any point: go to IDLE on the next edge, cnt=0, pwm_out=0 one cycle later. done is not set.
- Output rule:
  - pwm_out[i] is registered, equal to (state==RUN) & (cnt < active_pulse[i]).
  - One cycle of latency relative to cnt.
- Clamping, applied at shadow load:
  - An active_period below 2 is forced to 2.
  - pulse >= period gives a constant-high output; pulse = 0 gives a constant-low output.
- Simultaneous events:
  - A write-1-clear of done in the same cycle as a frame wrap leaves done=1 (set wins).
  - A PERIOD or PULSE write in the frame's last cycle takes effect in the new frame, because the write and the shadow load happen on the same edge and the new data is used.
- Reset asserted mid-frame: all state returns to reset values immediately (asynchronously); pwm_out drops to 0.
- Arithmetic: unsigned CNT_W-bit compares only; cnt never exceeds active_period-1, so no overflow.

Decomposition:
- Shared package holds:
  - register address constants (ADDR_CTRL, ADDR_STATUS, ADDR_PERIOD, ADDR_PULSE0);
  - CTRL bit indices;
  - the IDLE/RUN state encoding.
- One natural sub-module, niosII_system_servo_pwm_chan: per-channel shadow register plus compare and output flop, instantiated NUM_CH times.
- The top level owns the bus decode, frame counter and FSM.

Test Plan:
- Reset then read addresses 0..7.
  - Required: 0, 0, 1000000, 0, then 75000 four times, each on the cycle after the read strobe.
- PERIOD=10, PULSE0=3, PULSE1=0, PULSE2=10, enable=1.
  - Required: ch0 high 3 of every 10 clocks, ch1 always low, ch2 always high; done set every 10 clocks.
- Mid-frame, write PULSE0=7.
  - Required: the current frame keeps width 3; the next frame onward has width 7.
- Enable irq_en, wait for a frame.
  - Required: irq=1. Writing STATUS=1 drops irq the next cycle.
  - Writing STATUS=1 exactly in the wrap cycle leaves done=1.
- PERIOD=1 or PERIOD=0.
  - Required: the frame length is 2 clocks; a PULSE0=1 output toggles every clock.
- Disable mid-frame, then assert reset_n low mid-frame.
  - Required: pwm_out goes to 0, cnt goes to 0, done is unchanged on disable.
  - On reset, all registers return to their defaults asynchronously.

Source files
------------

// File: rtl/niosii_system_servo_pwm_pkg.sv
// Purpose: shared register map, CTRL bit positions and FSM encoding for the servo PWM block.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package niosii_system_servo_pwm_pkg;

  // Word addresses on the Avalon-MM slave
  localparam logic [2:0] ADDR_CTRL   = 3'd0;
  localparam logic [2:0] ADDR_STATUS = 3'd1;
  localparam logic [2:0] ADDR_PERIOD = 3'd2;
  localparam logic [2:0] ADDR_RSVD   = 3'd3;
  localparam logic [2:0] ADDR_PULSE0 = 3'd4;

  // CTRL register bit indices
  localparam int CTRL_EN_BIT     = 0;
  localparam int CTRL_IRQ_EN_BIT = 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/niosii_system_servo_pwm_if.sv
// Purpose: Avalon-MM slave bus bundle (address/strobes/data) for the servo PWM peripheral.
// Latency: readdata is registered by the slave, valid the cycle after a read strobe.
// Backpressure: none; the slave accepts every access (no waitrequest).
// Ports: address[2:0], chipselect, read, write, writedata[31:0] from master; readdata[31:0] from slave.
interface niosii_system_servo_pwm_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, read, write, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, read, write, writedata,
    output readdata
  );
endinterface

// File: rtl/niosii_system_servo_pwm_chan.sv
// Purpose: one PWM channel: active pulse-width shadow plus compare against the frame counter.
// Latency: pwm is registered, one cycle behind cnt.
// Backpressure: none; shadow reloads only when load is pulsed at a frame boundary.
// Ports: clock, reset_n, load (shadow reload strobe), pulse_prog (value to load),
//        run (FSM in RUN), cnt (frame counter), pwm (registered output).
module niosii_system_servo_pwm_chan #(
  parameter int CNT_W         = 20,
  parameter int DEFAULT_PULSE = 75000
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  logic [CNT_W-1:0] pulse_prog,
  input  logic             run,
  input  logic [CNT_W-1:0] cnt,
  output logic             pwm
);

  localparam logic [CNT_W-1:0] RST_PULSE = CNT_W'(DEFAULT_PULSE);

  logic [CNT_W-1:0] active_pulse_q, active_pulse_d;
  logic             pwm_q, pwm_d;

  // pulse >= period is naturally constant-high and pulse = 0 constant-low,
  // because cnt only ever spans 0..period-1.
  always_comb begin
    active_pulse_d = active_pulse_q;
    if (load) begin
      active_pulse_d = pulse_prog;
    end
    pwm_d = run & (cnt < active_pulse_q);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      active_pulse_q <= RST_PULSE;
      pwm_q          <= 1'b0;
    end else begin
      active_pulse_q <= active_pulse_d;
      pwm_q          <= pwm_d;
    end
  end

  assign pwm = pwm_q;

endmodule

// File: rtl/niosii_system_servo_pwm.sv
// Purpose: Avalon-MM servo PWM peripheral: register file, frame counter, IDLE/RUN FSM, NUM_CH channels.
// Latency: read data 1 cycle after strobe; writes apply on the strobe edge; pwm lags cnt by 1 cycle.
// Backpressure: none; every bus access completes in one cycle.
// Ports: clock, reset_n (async, active-low), bus (Avalon slave modport),
//        pwm_out[NUM_CH-1:0] (registered pulses), irq (done & irq_en).
module niosii_system_servo_pwm
  import niosii_system_servo_pwm_pkg::*;
#(
  parameter int NUM_CH         = 4,
  parameter int CNT_W          = 20,
  parameter int DEFAULT_PERIOD = 1000000,
  parameter int DEFAULT_PULSE  = 75000
) (
  input  logic                   clock,
  input  logic                   reset_n,
  niosii_system_servo_pwm_if.slave bus,
  output logic [NUM_CH-1:0]      pwm_out,
  output logic                   irq
);

  localparam logic [CNT_W-1:0] RST_PERIOD = CNT_W'(DEFAULT_PERIOD);
  localparam logic [CNT_W-1:0] RST_PULSE  = CNT_W'(DEFAULT_PULSE);
  localparam logic [CNT_W-1:0] MIN_PERIOD = CNT_W'(2);
  localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

  logic             wr_en, rd_en;
  logic [1:0]       ctrl_q, ctrl_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] pulse_q [NUM_CH];
  logic [CNT_W-1:0] pulse_d [NUM_CH];
  logic [31:0]      readdata_q, readdata_d;
  logic [31:0]      rd_mux;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] active_period_q, active_period_d;
  logic             enable, run, frame_wrap, shadow_load;

  assign wr_en  = bus.chipselect & bus.write;
  assign rd_en  = bus.chipselect & bus.read;
  assign enable = ctrl_q[CTRL_EN_BIT];
  assign run    = (state_q == ST_RUN);

  // Last cycle of a frame; suppressed when software disables so done stays put.
  assign frame_wrap = run && enable && (cnt_q == active_period_q - ONE);

  // Programmed registers. The _d values feed the shadow load so a write landing
  // on the frame's last edge is picked up by the frame that starts there.
  always_comb begin
    ctrl_d   = ctrl_q;
    period_d = period_q;
    for (int i = 0; i < NUM_CH; i++) begin
      pulse_d[i] = pulse_q[i];
    end
    if (wr_en) begin
      case (bus.address)
        ADDR_CTRL:   ctrl_d   = bus.writedata[1:0];
        ADDR_PERIOD: period_d = bus.writedata[CNT_W-1:0];
        default: begin
          for (int i = 0; i < NUM_CH; i++) begin
            if (bus.address == ADDR_PULSE0 + 3'(i)) begin
              pulse_d[i] = bus.writedata[CNT_W-1:0];
            end
          end
        end
      endcase
    end
  end

  // Sticky done: a frame wrap beats a simultaneous write-1-clear.
  always_comb begin
    done_d = done_q;
    if (wr_en && (bus.address == ADDR_STATUS) && bus.writedata[0]) begin
      done_d = 1'b0;
    end
    if (frame_wrap) begin
      done_d = 1'b1;
    end
  end

  // Read mux sees pre-write register values, so a same-cycle read/write returns old data.
  always_comb begin
    rd_mux = '0;
    case (bus.address)
      ADDR_CTRL:   rd_mux[1:0]       = ctrl_q;
      ADDR_STATUS: rd_mux[0]         = done_q;
      ADDR_PERIOD: rd_mux[CNT_W-1:0] = period_q;
      ADDR_RSVD:   rd_mux            = '0;
      default: begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (bus.address == ADDR_PULSE0 + 3'(i)) begin
            rd_mux[CNT_W-1:0] = pulse_q[i];
          end
        end
      end
    endcase
    readdata_d = rd_en ? rd_mux : readdata_q;
  end

  // Frame FSM and counter
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    active_period_d = active_period_q;
    shadow_load     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (enable) begin
          state_d     = ST_RUN;
          shadow_load = 1'b1;
        end
      end
      ST_RUN: begin
        if (!enable) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (frame_wrap) begin
          cnt_d       = '0;
          shadow_load = 1'b1;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
    endcase
    // A one-clock frame cannot hold a wrap, so short periods are forced to 2.
    if (shadow_load) begin
      active_period_d = (period_d < MIN_PERIOD) ? MIN_PERIOD : period_d;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q          <= '0;
      done_q          <= 1'b0;
      period_q        <= RST_PERIOD;
      for (int i = 0; i < NUM_CH; i++) begin
        pulse_q[i] <= RST_PULSE;
      end
      readdata_q      <= '0;
      state_q         <= ST_IDLE;
      cnt_q           <= '0;
      active_period_q <= RST_PERIOD;
    end else begin
      ctrl_q          <= ctrl_d;
      done_q          <= done_d;
      period_q        <= period_d;
      for (int i = 0; i < NUM_CH; i++) begin
        pulse_q[i] <= pulse_d[i];
      end
      readdata_q      <= readdata_d;
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      active_period_q <= active_period_d;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    niosii_system_servo_pwm_chan #(
      .CNT_W         (CNT_W),
      .DEFAULT_PULSE (DEFAULT_PULSE)
    ) u_chan (
      .clock      (clock),
      .reset_n    (reset_n),
      .load       (shadow_load),
      .pulse_prog (pulse_d[g]),
      .run        (run),
      .cnt        (cnt_q),
      .pwm        (pwm_out[g])
    );
  end

  assign bus.readdata = readdata_q;
  assign irq          = done_q & ctrl_q[CTRL_IRQ_EN_BIT];

endmodule
